// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared byte-addressed, big-endian 24-bit data memory.
// Each access runs IDLE -> ACCESS -> DONE with a bounds check made at grant time.
module dmem_arbiter #(
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 24,
    parameter int MEM_BYTES = 128,
    parameter bit RR_EN     = 1'b1
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              req0_i,
    input  logic              write0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              req1_i,
    input  logic              write1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack0_o,
    output logic              err0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              ack1_o,
    output logic              err1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_write_data_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    input  logic [DATA_W-1:0] mem_read_data_i,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 3);

    logic [1:0]        state_q, state_d;
    logic              last_grant_q;
    logic              grant_q;
    logic              write_q;
    logic              in_range_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata_q [2];

    logic              any_req;
    logic              winner;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req = req0_i | req1_i;

    // On a tie the round-robin mode favours the port that did not win last time.
    always_comb begin
        winner = 1'b0;
        if (RR_EN) begin
            if (req0_i && req1_i) winner = ~last_grant_q;
            else                  winner = req1_i;
        end else begin
            winner = ~req0_i;
        end
    end

    assign sel_write = winner ? write1_i : write0_i;
    assign sel_addr  = winner ? addr1_i  : addr0_i;
    assign sel_wdata = winner ? wdata1_i : wdata0_i;

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = any_req ? S_ACCESS : S_IDLE;
            S_ACCESS: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            write_q      <= 1'b0;
            in_range_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= '0;
            if (state_q == S_IDLE && any_req) begin
                last_grant_q <= winner;
                grant_q      <= winner;
                write_q      <= sel_write;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                in_range_q   <= (sel_addr <= MAX_ADDR);
            end
            if (state_q == S_ACCESS) begin
                ack_q[grant_q] <= 1'b1;
                err_q[grant_q] <= ~in_range_q;
                if (!in_range_q)   rdata_q[grant_q] <= '0;
                else if (!write_q) rdata_q[grant_q] <= mem_read_data_i;
            end
        end
    end

    // Strobes and acks are masked by reset so an aborted access never commits or completes.
    assign mem_write_o      = (state_q == S_ACCESS) & in_range_q &  write_q & reset_n_i;
    assign mem_read_o       = (state_q == S_ACCESS) & in_range_q & ~write_q & reset_n_i;
    assign mem_address_o    = addr_q;
    assign mem_write_data_o = wdata_q;
    assign busy_o           = (state_q != S_IDLE);

    assign ack0_o   = ack_q[0] & reset_n_i;
    assign ack1_o   = ack_q[1] & reset_n_i;
    assign err0_o   = err_q[0];
    assign err1_o   = err_q[1];
    assign rdata0_o = rdata_q[0];
    assign rdata1_o = rdata_q[1];

endmodule
